exp_stream_controller: RTL
==========================

Name: exp_stream_controller

Overview:
Upstream sequencer for the exponential unit. Accepts a stream of UQ0.16 operands on a valid/ready input. For each operand it issues one start/done transaction to the exponential unit and returns each UQ2.16 result on a valid/ready output. It also accumulates a running sum over batches of N results, which provides the softmax-style denominator for the downstream normaliser.

Parameters:
N, 8, results per batch; range 2..256.
SUM_W, 21, accumulator width; must be at least 18 + ceil(log2(N)).
TIMEOUT, 1023, watchdog limit in cycles; used only with EXP_TIMEOUT_EN.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  operand valid
in_ready  out  1  controller can accept an operand
in_x  in  16  operand, UQ0.16
exp_start  out  1  start to exponential unit
exp_x  out  16  operand to exponential unit
exp_done  in  1  done from exponential unit; level signal
exp_intpart  in  2  result integer bits
exp_fracpart  in  16  result fraction bits
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_data  out  18  {intpart, fracpart}, UQ2.16
out_last  out  1  high with the Nth result of a batch
sum_valid  out  1  one-cycle pulse, batch sum valid
sum  out  SUM_W  batch sum, UQ(SUM_W-16).16
err  out  1  sticky timeout flag; always 0 without EXP_TIMEOUT_EN

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. All outputs 0 except in_ready=1. Batch counter=0, accumulator=0. A reset asserted mid-transaction abandons the transaction; exp_start drops immediately.
- IDLE: in_ready=1. When in_valid and in_ready are both high, latch in_x into exp_x and go to START. No other state accepts operands.
- START: exp_start=1 for exactly one cycle; go to CLR.
- CLR: wait for exp_done=0. This rejects a stale done left over from the previous run. Go to WAIT.
- WAIT: when exp_done=1, register {exp_intpart, exp_fracpart} into out_data and go to OUT.
- OUT: out_valid=1. out_data and out_last stay stable until out_ready=1. On the accept cycle, add zero-extended out_data into the accumulator and increment the batch counter.
  - If the counter was N-1: next cycle drive sum_valid=1 with sum = final total; clear the accumulator and counter in the same cycle. Then go to IDLE.
  - Otherwise go to IDLE.
- exp_x is held stable from the START cycle until out_valid rises.
- Latency: operand accepted at cycle t → exp_start at t+1. exp_done seen at cycle d → out_valid at d+1. sum_valid at (accept of last result)+1.
- If out_ready is high on the first out_valid cycle, the handshake completes in that cycle. The next operand can be accepted the following cycle.
- Accumulator never wraps when SUM_W meets its minimum: max per result 3.99998, times N.
- sum holds its last value between pulses. It is cleared only by reset or by the start of the next batch total.

Optional Feature:
EXP_TIMEOUT_EN.
- Defined: a cycle counter runs in CLR and WAIT. If it reaches TIMEOUT before exp_done=1, set err=1 (sticky until reset) and force out_data=18'h3FFFF. That saturated result is accumulated normally. Go to OUT.
- Undefined: no counter; the controller waits indefinitely; err is tied to 0.

Test Plan:
- Single operand: bench exp model with latency 12 returns int=1, frac=0. Drive in_x=16'h0000 → exp_start pulses 1 cycle after accept; out_data=18'h10000 at done+1; out_last=0.
- Batch sum: 8 operands, each model result 18'h10000, out_ready tied high → out_last on the 8th; sum_valid pulses once with sum=21'h80000; accumulator then 0.
- Backpressure: model returns int=2, frac=16'h86AE for in_x=16'hED3C; hold out_ready low 5 cycles → out_valid=1, out_data=18'h286AE stable throughout; in_ready=0; exp_start stays 0.
- Stale done: model holds exp_done=1 until the next start, then drops it for 3 cycles → controller waits in CLR; result is captured only after the new rising done.
- Reset mid-run: assert rst low during WAIT → immediately out_valid=0, exp_start=0, in_ready=1; a subsequent batch of 8 sums from zero.
- Timeout (EXP_TIMEOUT_EN, TIMEOUT=20): model never asserts done → after 20 cycles err=1, out_data=18'h3FFFF, out_valid=1.

Source files
------------

// File: rtl/exp_stream_controller.sv
// exp_stream_controller: feeds UQ0.16 operands one at a time through the
// exponential unit (start/done handshake), returns UQ2.16 results on a
// valid/ready stream and pulses the running sum of every batch of N results.
// Optional feature macro: EXP_TIMEOUT_EN adds a done watchdog that saturates
// the result to 18'h3FFFF and raises a sticky err flag.
module exp_stream_controller #(
  parameter int unsigned N       = 8,
  parameter int unsigned SUM_W   = 21,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_x,
  output logic             exp_start,
  output logic [15:0]      exp_x,
  input  logic             exp_done,
  input  logic [1:0]       exp_intpart,
  input  logic [15:0]      exp_fracpart,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [17:0]      out_data,
  output logic             out_last,
  output logic             sum_valid,
  output logic [SUM_W-1:0] sum,
  output logic             err
);

  localparam int unsigned CntW = $clog2(N);
  localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

  typedef enum logic [2:0] {StIdle, StStart, StClr, StWait, StOut} state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [SUM_W-1:0] acc_q;
  logic [SUM_W-1:0] acc_sum;

  // Running total including the result being handed off this cycle.
  assign acc_sum = acc_q + SUM_W'(out_data);

`ifdef EXP_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

  logic [TmoW-1:0] tmo_q;
  logic            tmo_hit;

  // Last waiting cycle before the watchdog gives up on exp_done.
  assign tmo_hit = (tmo_q == TmoLast);
`else
  assign err = 1'b0;
`endif

  // Sequencer FSM; every output is registered here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      in_ready  <= 1'b1;
      exp_start <= 1'b0;
      exp_x     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      sum_valid <= 1'b0;
      sum       <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
`ifdef EXP_TIMEOUT_EN
      tmo_q     <= '0;
      err       <= 1'b0;
`endif
    end else begin
      sum_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            exp_x     <= in_x;
            exp_start <= 1'b1;
            in_ready  <= 1'b0;
            state_q   <= StStart;
          end
        end
        StStart: begin
          exp_start <= 1'b0;
          state_q   <= StClr;
`ifdef EXP_TIMEOUT_EN
          tmo_q     <= '0;
`endif
        end
        StClr: begin
          // A done still high from the previous run is not ours; wait for it to fall.
          if (!exp_done) begin
            state_q <= StWait;
          end
`ifdef EXP_TIMEOUT_EN
          tmo_q <= tmo_q + 1'b1;
          if (tmo_hit) begin
            err       <= 1'b1;
            out_data  <= '1;
            out_last  <= (cnt_q == LastCnt);
            out_valid <= 1'b1;
            state_q   <= StOut;
          end
`endif
        end
        StWait: begin
`ifdef EXP_TIMEOUT_EN
          tmo_q <= tmo_q + 1'b1;
          if (!exp_done && tmo_hit) begin
            err       <= 1'b1;
            out_data  <= '1;
            out_last  <= (cnt_q == LastCnt);
            out_valid <= 1'b1;
            state_q   <= StOut;
          end
`endif
          if (exp_done) begin
            out_data  <= {exp_intpart, exp_fracpart};
            out_last  <= (cnt_q == LastCnt);
            out_valid <= 1'b1;
            state_q   <= StOut;
          end
        end
        StOut: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= StIdle;
            if (cnt_q == LastCnt) begin
              sum       <= acc_sum;
              sum_valid <= 1'b1;
              acc_q     <= '0;
              cnt_q     <= '0;
            end else begin
              acc_q <= acc_sum;
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
